icache_fill_ctrl: RTL and testbench
===================================

# icache_fill_ctrl

Direct-mapped instruction cache with miss-fill controller; the responder side of the fetch stage's instruction interface. Takes the fetch PC each cycle and returns the instruction word on a hit, or asserts `cache_stall` and refills the missing line from main memory over a pipelined request/valid interface. Sits between the fetch stage and the memory arbiter.

## Interface
- `LINES`, 32: number of cache lines (index width = log2(LINES)).
- `WORDS`, 8: 16-bit words per line (16-byte line).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  fetch address valid this cycle.
- `fetch_addr`  in  16  byte PC; bit 0 ignored.
- `instr`  out  16  instruction word to fetch.
- `cache_stall`  out  1  miss in progress; fetch must hold its PC.
- `mem_req`  out  1  one word read request this cycle.
- `mem_addr`  out  16  word-aligned byte address of request.
- `mem_valid`  in  1  read data returning this cycle.
- `mem_data`  in  16  returned word, in request order.

## Operation
- Address split (defaults): offset `[3:1]`, index `[8:4]`, tag `[15:9]` (7 bits).
- Storage: data array LINES×WORDS×16, tag array LINES×7, valid bit per line.
- Hit (`fetch_en` & valid & tag match, state IDLE): `instr` = stored word, combinational; `cache_stall`=0.
- Miss in IDLE: `cache_stall`=1 combinationally same cycle; tag/index latched; next state FILL.
- FILL: `mem_req`=1 for WORDS consecutive cycles, `mem_addr` = {latched tag, index, req_cnt, 1'b0}, req_cnt 0→7. Each `mem_valid` writes `mem_data` to word rx_cnt of the line, rx_cnt 0→7. On 8th return: tag written, valid set, state→IDLE.
- Whenever `cache_stall`=1, `instr` forced to 16'h0000 (never presents opcode 4'hF during a stall).
- `fetch_en`=0: no lookup, `cache_stall`=0, `instr`=0.
- `fetch_addr` changing during FILL: ignored; fill completes for latched line, then new address looked up in IDLE.
- `mem_valid` in IDLE, or after 8 returns: ignored, no array write.
- Controller counts returns, not cycles; any memory latency ≥1 is correct.

## Timing
- Reset values: state IDLE, all valid bits 0, req_cnt/rx_cnt 0, `mem_req`=0, `mem_addr`=0, `cache_stall`=0, `instr`=0 while `rst` low.
- Reset mid-fill: fill aborted, line remains invalid, counters cleared.
- Hit latency: 0 cycles (same-cycle data).
- Miss, memory latency L: miss seen cycle 0; requests cycles 1–8; returns cycles 1+L..8+L; line valid from cycle 9+L; hit and `cache_stall`=0 in cycle 9+L. L=4 → 13 stall cycles.
- FSM: IDLE --miss--> FILL --8th mem_valid--> IDLE. No other transitions except reset.
- Tag/valid written on same edge as last data word; no partial-line hits.

## Structure
- Package `icache_pkg`: ADDR_W=16, WORD_W=16, TAG_W, IDX_W, OFF_W, LINES, WORDS, state enum {IDLE, FILL}, address-field extraction functions.
- Sub-module `icache_array`: data + tag + valid storage, one combinational read port (index, offset), one synchronous word write port, tag/valid write, async clear of valid on reset.
- Top: FSM, req/rx counters, hit compare, output muxing.

## Test plan
- Cold miss: reset, `fetch_en`=1, `fetch_addr`=0x0000, L=4 → `cache_stall`=1 for 13 cycles, `mem_addr` 0x0000,0x0002..0x000E on cycles 1–8, then `instr`=mem[0x0000], stall 0.
- Same-line hits after fill: addresses 0x0002..0x000E → stall 0, `instr` matches memory each cycle, `mem_req` stays 0.
- Conflict: fill 0x0000, then fetch 0x0200 (same index, tag 1) → miss, refill; return to 0x0000 → miss again.
- Stall masking: memory word at 0x0100 = 0xF000; during its fill `instr` = 0x0000 every stall cycle; 0xF000 appears only after stall drops.
- Address change mid-fill: miss on 0x0010, change `fetch_addr` to 0x0040 on cycle 3 → requests stay 0x0010..0x001E; then separate miss/fill for 0x0040.
- Reset mid-fill: assert `rst` low at cycle 6 of a fill → `mem_req`=0, stall 0 immediately; after release, same address misses and refills fully.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared parameters, FSM state type and address-field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;
    localparam int LINES  = 32;
    localparam int WORDS  = 8;
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 1;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    // Byte address layout: {tag, index, word offset, byte-in-word}
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W+1 +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[1 +: OFF_W];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Data, tag and valid storage for the instruction cache: one combinational
// read port, one synchronous word write port, tag/valid update per line.
module icache_array
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [WORD_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              line_done,
    input  logic [TAG_W-1:0]  line_tag
);

    logic [WORD_W-1:0] data_mem [LINES*WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid;

    assign rd_data  = data_mem[{rd_idx, rd_off}];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_idx, wr_off}] <= wr_data;
        end
        if (line_done) begin
            tag_mem[wr_idx] <= line_tag;
        end
    end

    // Only the valid bits need reset; stale data/tags are harmless once invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (line_done) begin
            valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache front end: same-cycle hits, and on a miss
// a pipelined line refill that counts returned words rather than cycles.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [WORD_W-1:0] instr,
    output logic              cache_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [WORD_W-1:0] mem_data
);

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    state_t            state;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [OFF_W-1:0]  req_cnt;
    logic [OFF_W-1:0]  rx_cnt;
    logic [OFF_W-1:0]  req_nxt;

    logic [WORD_W-1:0] rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              lookup;
    logic              tag_match;
    logic              hit;
    logic              miss;
    logic              wr_en;
    logic              line_done;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = fetch_addr[0];

    assign lookup    = rst && fetch_en && (state == IDLE);
    assign tag_match = rd_valid && (rd_tag == addr_tag(fetch_addr));
    assign hit       = lookup && tag_match;
    assign miss      = lookup && !tag_match;

    assign cache_stall = miss || (state == FILL);
    assign instr       = hit ? rd_data : '0;

    assign wr_en     = (state == FILL) && mem_valid;
    assign line_done = wr_en && (rx_cnt == LAST_WORD);
    assign req_nxt   = req_cnt + OFF_W'(1);

    icache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (addr_idx(fetch_addr)),
        .rd_off    (addr_off(fetch_addr)),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_idx    (fill_idx),
        .wr_off    (rx_cnt),
        .wr_data   (mem_data),
        .line_done (line_done),
        .line_tag  (fill_tag)
    );

    // Request issue and return counting run independently, so any memory
    // latency of one or more cycles completes the line correctly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fill_tag <= '0;
            fill_idx <= '0;
            req_cnt  <= '0;
            rx_cnt   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state    <= FILL;
                        fill_tag <= addr_tag(fetch_addr);
                        fill_idx <= addr_idx(fetch_addr);
                        req_cnt  <= '0;
                        rx_cnt   <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {addr_tag(fetch_addr), addr_idx(fetch_addr),
                                     {OFF_W{1'b0}}, 1'b0};
                    end
                end
                FILL: begin
                    if (mem_req) begin
                        if (req_cnt == LAST_WORD) begin
                            mem_req  <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            req_cnt  <= req_nxt;
                            mem_addr <= {fill_tag, fill_idx, req_nxt, 1'b0};
                        end
                    end
                    if (mem_valid) begin
                        if (rx_cnt == LAST_WORD) begin
                            state   <= IDLE;
                            rx_cnt  <= '0;
                            req_cnt <= '0;
                        end else begin
                            rx_cnt <= rx_cnt + OFF_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with a fixed-latency memory responder.
module tb_icache_fill_ctrl;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [15:0] fetch_addr;
    logic [15:0] instr;
    logic        cache_stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_data;

    int vectors;
    int miscompares;
    int cyc;
    int          dueQ[$];
    logic [15:0] addrQ[$];

    icache_fill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .instr       (instr),
        .cache_stall (cache_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main-memory contents; 0x0100 holds an opcode-F word for the masking test
    function automatic logic [15:0] memWord(input logic [15:0] a);
        if (a == 16'h0100) return 16'hF000;
        return a ^ 16'h3C5A;
    endfunction

    // Requests seen in cycle n are answered in cycle n+LAT
    always @(negedge clk) begin
        if (rst && mem_req) begin
            dueQ.push_back(cyc + LAT);
            addrQ.push_back(mem_addr);
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst) begin
            dueQ.delete();
            addrQ.delete();
            mem_valid = 1'b0;
            mem_data  = 16'hDEAD;
        end else if (dueQ.size() > 0 && dueQ[0] == cyc) begin
            mem_valid = 1'b1;
            mem_data  = memWord(addrQ[0]);
            void'(dueQ.pop_front());
            void'(addrQ.pop_front());
        end else begin
            mem_valid = 1'b0;
            mem_data  = 16'hDEAD;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] addr);
        fetch_en   = en;
        fetch_addr = addr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Checks a full miss/fill starting in the current cycle (cycle 0)
    task automatic fillSeq(input logic [15:0] addr, input int chgCycle,
                           input logic [15:0] chgAddr, input bit expectHit);
        logic [15:0] base;
        base = {addr[15:4], 4'h0};
        for (int c = 0; c < 9 + LAT; c++) begin
            @(negedge clk);
            checkOutput("stall", {15'd0, cache_stall}, 16'd1);
            checkOutput("instr_masked", instr, 16'h0000);
            if (c >= 1 && c <= 8) begin
                checkOutput("mem_req", {15'd0, mem_req}, 16'd1);
                checkOutput("mem_addr", mem_addr, base + 16'(2 * (c - 1)));
            end else begin
                checkOutput("mem_req_off", {15'd0, mem_req}, 16'd0);
            end
            nextCycle();
            if (c + 1 == chgCycle) applyStimulus(1'b1, chgAddr);
        end
        if (expectHit) begin
            @(negedge clk);
            checkOutput("stall_done", {15'd0, cache_stall}, 16'd0);
            checkOutput("instr_hit", instr, memWord(addr));
            checkOutput("mem_req_done", {15'd0, mem_req}, 16'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b0;
        mem_valid   = 1'b0;
        mem_data    = 16'hDEAD;
        applyStimulus(1'b1, 16'h0000);

        // Reset state with a fetch already pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", {15'd0, cache_stall}, 16'd0);
        checkOutput("rst_instr", instr, 16'h0000);
        checkOutput("rst_mem_req", {15'd0, mem_req}, 16'd0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);

        // Cold miss on 0x0000
        nextCycle();
        rst = 1'b1;
        fillSeq(16'h0000, -1, 16'h0000, 1'b1);

        // Same-line hits
        for (int a = 2; a <= 14; a += 2) begin
            nextCycle();
            applyStimulus(1'b1, 16'(a));
            @(negedge clk);
            checkOutput("hit_stall", {15'd0, cache_stall}, 16'd0);
            checkOutput("hit_instr", instr, memWord(16'(a)));
            checkOutput("hit_mem_req", {15'd0, mem_req}, 16'd0);
        end

        // Fetch disabled on a valid line
        nextCycle();
        applyStimulus(1'b0, 16'h0000);
        @(negedge clk);
        checkOutput("noen_stall", {15'd0, cache_stall}, 16'd0);
        checkOutput("noen_instr", instr, 16'h0000);

        // Conflict: same index, different tag, then back again
        nextCycle();
        applyStimulus(1'b1, 16'h0200);
        fillSeq(16'h0200, -1, 16'h0000, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 16'h0000);
        fillSeq(16'h0000, -1, 16'h0000, 1'b1);

        // Opcode-F word stays hidden during its fill
        nextCycle();
        applyStimulus(1'b1, 16'h0100);
        fillSeq(16'h0100, -1, 16'h0000, 1'b1);

        // Address change mid-fill, then a separate fill for the new line
        nextCycle();
        applyStimulus(1'b1, 16'h0010);
        fillSeq(16'h0010, 3, 16'h0040, 1'b0);
        fillSeq(16'h0040, -1, 16'h0000, 1'b1);

        // Reset in cycle 6 of a fill
        nextCycle();
        applyStimulus(1'b1, 16'h0300);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("pre_rst_stall", {15'd0, cache_stall}, 16'd1);
            nextCycle();
        end
        rst = 1'b0;
        #1;
        checkOutput("midrst_mem_req", {15'd0, mem_req}, 16'd0);
        checkOutput("midrst_stall", {15'd0, cache_stall}, 16'd0);
        checkOutput("midrst_mem_addr", mem_addr, 16'h0000);
        checkOutput("midrst_instr", instr, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        fillSeq(16'h0300, -1, 16'h0000, 1'b1);

        // Earlier line survives unrelated fills but not the reset
        nextCycle();
        applyStimulus(1'b1, 16'h0040);
        @(negedge clk);
        checkOutput("post_rst_miss", {15'd0, cache_stall}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
